modulo_counter: RTL and testbench
=================================

Name: modulo_counter

Overview:
- Parameterised synchronous up/down modulo-n counter with parallel load and enable; building block for the alarm-clock time chain (seconds/minutes/hours digits).
- Wraps n-1→0 counting up and 0→n-1 counting down.
- Raises a terminal-count strobe on the wrapping cycle so that instances cascade.

Parameters:
- x, 3, counter width in bits; legal 1..16.
- n, 5, modulus; legal 2..2^x. Count range is 0..n-1. Elaboration-time error if n<2 or n>2^x.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset=0 clears; reset=1 runs).
- en  input  1  count enable.
- load  input  1  synchronous parallel load, independent of en.
- count_down  input  1  direction: 0 = up, 1 = down; sampled only while counting.
- load_value  input  x  value loaded when load=1.
- count  output  x  registered counter value.
- tc  output  1  combinational terminal count: counter wraps on the next clk edge.

Behaviour:
- Reset: reset=0 forces count=0 immediately, without waiting for clk. count holds 0 while reset=0. First update occurs on the first rising clk after reset returns to 1. tc=0 during reset.
- Priority at each rising clk, highest first: load, then en, then hold.
- Load (load=1): count <= load_value on the same edge; en and count_down are ignored. One-cycle latency. Out-of-range handling per Optional Feature.
- Count up (load=0, en=1, count_down=0): count <= (count==n-1) ? 0 : count+1.
- Count down (load=0, en=1, count_down=1): count <= (count==0) ? n-1 : count-1.
- Hold (load=0, en=0): count unchanged, whatever count_down is.
- tc = reset & ~load & en & ((~count_down & count==n-1) | (count_down & count==0)). Purely combinational from the current state and inputs. Asserts exactly in the cycle preceding a wrap edge.
- Direction change: takes effect on the next enabled edge; no dead cycle.
- Arithmetic: compare against n-1 sized to x bits. When n=2^x, the natural overflow and wrap values must agree.
- Reachable count values are always 0..n-1, given a legal load.
- No X propagation: all outputs defined from reset onward.

Optional Feature:
- Macro: MODULO_COUNTER_LOAD_CLAMP_EN.
- Defined: a load_value >= n loads n-1 (saturating clamp).
- Undefined: a load_value >= n loads 0.
- In both builds a load_value < n loads verbatim, and count never leaves 0..n-1.

Test Plan (x=3, n=5):
- Reset mid-count: count at 3, drive reset=0 between clk edges -> count=0 at once, before the next edge; holds 0 while reset=0; tc=0.
- Count up wrap: reset released, en=1, count_down=0 for 6 edges -> 1,2,3,4,0,1; tc=1 only while count=4.
- Count down wrap: load 1, then en=1, count_down=1 for 3 edges -> 0,4,3; tc=1 only while count=0.
- Load priority: en=1, load=1, load_value=3 at count=4 -> count=3 next edge, no wrap, tc=0. Load with en=0, load_value=4 -> count=4.
- Hold: en=0, load=0, toggle count_down for 4 edges -> count unchanged, tc=0.
- Out-of-range load: load_value=7 -> count=4 with MODULO_COUNTER_LOAD_CLAMP_EN, 0 without.

Source files
------------

// File: rtl/modulo_counter.sv
// Up/down modulo-n counter with parallel load, enable and a cascade terminal-count strobe.
// Build option: define MODULO_COUNTER_LOAD_CLAMP_EN to clamp out-of-range loads to n-1 (default loads 0).
module modulo_counter #(
  parameter int x = 3,
  parameter int n = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic         count_down,
  input  logic [x-1:0] load_value,
  output logic [x-1:0] count,
  output logic         tc
);

  generate
    if (x < 1 || x > 16) begin : g_bad_width
      $error("modulo_counter: x=%0d outside 1..16", x);
    end
    if (n < 2 || n > (2 ** x)) begin : g_bad_modulus
      $error("modulo_counter: n=%0d outside 2..2^x", n);
    end
  endgenerate

  // Top of range sized to x bits so n == 2^x compares against all-ones.
  localparam logic [x-1:0] C_MAX = x'(n - 1);

  logic [x-1:0] r_count;
  logic [x-1:0] w_count_next;
  logic [x-1:0] w_load_fixed;
  logic         w_at_max;
  logic         w_at_zero;
  logic         w_load_oor;

  assign w_at_max   = (r_count == C_MAX);
  assign w_at_zero  = (r_count == '0);
  assign w_load_oor = (load_value > C_MAX);

`ifdef MODULO_COUNTER_LOAD_CLAMP_EN
  assign w_load_fixed = w_load_oor ? C_MAX : load_value;
`else
  assign w_load_fixed = w_load_oor ? '0 : load_value;
`endif

  always_comb begin
    w_count_next = r_count;
    if (load) begin
      w_count_next = w_load_fixed;
    end else if (en) begin
      if (count_down) begin
        w_count_next = w_at_zero ? C_MAX : (r_count - x'(1));
      end else begin
        w_count_next = w_at_max ? '0 : (r_count + x'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;
  // Strobe marks the cycle whose edge wraps, so a following stage can use it as its enable.
  assign tc = reset & ~load & en & ((~count_down & w_at_max) | (count_down & w_at_zero));

endmodule

// File: tb/tb_modulo_counter.sv
// Self-checking bench for modulo_counter (x=3, n=5): vector table, corner sequences, random vs model.
module tb_modulo_counter;

  localparam int X = 3;
  localparam int N = 5;
`ifdef MODULO_COUNTER_LOAD_CLAMP_EN
  localparam int OOR = N - 1;
`else
  localparam int OOR = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         load;
  logic         count_down;
  logic [X-1:0] load_value;
  logic [X-1:0] count;
  logic         tc;

  int total = 0;
  int bad   = 0;
  int m     = 0;

  always #5 clk = ~clk;

  modulo_counter #(.x(X), .n(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .count_down(count_down),
    .load_value(load_value),
    .count     (count),
    .tc        (tc)
  );

  typedef struct {
    bit ld;
    bit e;
    bit d;
    int lv;
    int exp_count;
    bit exp_tc;
    string name;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit ld, bit e, bit d, int lv, int ec, bit et, string nm);
    vec_t v;
    v.ld = ld; v.e = e; v.d = d; v.lv = lv;
    v.exp_count = ec; v.exp_tc = et; v.name = nm;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Reference: counting is arithmetic modulo N; tc means the step leaves 0..N-1.
  function automatic int model_next(int c, bit ld, bit e, bit d, int v);
    if (ld) return (v < N) ? v : OOR;
    if (e) return d ? (c + N - 1) % N : (c + 1) % N;
    return c;
  endfunction

  function automatic bit model_tc(int c, bit ld, bit e, bit d);
    if (ld || !e) return 1'b0;
    return d ? (c - 1 < 0) : (c + 1 >= N);
  endfunction

  task automatic apply(bit ld, bit e, bit d, int lv, int ec, bit et, string nm);
    @(negedge clk);
    load = ld; en = e; count_down = d; load_value = X'(lv);
    #1 chk({nm, "_tc"}, {15'd0, tc}, {15'd0, et});
    @(posedge clk);
    #1 chk({nm, "_cnt"}, {13'd0, count}, ec[15:0]);
    m = ec;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; load = 1'b0; count_down = 1'b0; load_value = '0;
    #2 chk("reset_cnt", {13'd0, count}, 16'd0);
    chk("reset_tc", {15'd0, tc}, 16'd0);
    @(negedge clk);
    en = 1'b1;
    #1 chk("reset_tc_en", {15'd0, tc}, 16'd0);
    @(posedge clk);
    #1 chk("reset_hold", {13'd0, count}, 16'd0);
    @(negedge clk);
    reset = 1'b1; en = 1'b0;

    vt.push_back(mk(0, 1, 0, 0, 1, 0, "up1"));
    vt.push_back(mk(0, 1, 0, 0, 2, 0, "up2"));
    vt.push_back(mk(0, 1, 0, 0, 3, 0, "up3"));
    vt.push_back(mk(0, 1, 0, 0, 4, 0, "up4"));
    vt.push_back(mk(0, 1, 0, 0, 0, 1, "up_wrap"));
    vt.push_back(mk(0, 1, 0, 0, 1, 0, "up5"));
    vt.push_back(mk(1, 0, 0, 1, 1, 0, "load1"));
    vt.push_back(mk(0, 1, 1, 0, 0, 0, "dn1"));
    vt.push_back(mk(0, 1, 1, 0, 4, 1, "dn_wrap"));
    vt.push_back(mk(0, 1, 1, 0, 3, 0, "dn2"));
    vt.push_back(mk(1, 0, 0, 4, 4, 0, "load4_noen"));
    vt.push_back(mk(1, 1, 0, 3, 3, 0, "load_prio"));
    vt.push_back(mk(0, 0, 1, 0, 3, 0, "hold1"));
    vt.push_back(mk(0, 0, 0, 0, 3, 0, "hold2"));
    vt.push_back(mk(0, 0, 1, 0, 3, 0, "hold3"));
    vt.push_back(mk(0, 0, 0, 0, 3, 0, "hold4"));
    vt.push_back(mk(1, 1, 1, 7, OOR, 0, "load_oor7"));
    vt.push_back(mk(1, 0, 0, 5, OOR, 0, "load_oor5"));
    vt.push_back(mk(1, 0, 0, 4, 4, 0, "load4"));
    vt.push_back(mk(0, 1, 1, 0, 3, 0, "dir_dn"));
    vt.push_back(mk(0, 1, 0, 0, 4, 0, "dir_up"));
    vt.push_back(mk(0, 1, 0, 0, 0, 1, "dir_wrap"));

    foreach (vt[i]) begin
      apply(vt[i].ld, vt[i].e, vt[i].d, vt[i].lv, vt[i].exp_count, vt[i].exp_tc, vt[i].name);
    end

    // Reset mid-count between edges, with a pending wrap that reset must suppress.
    apply(1, 0, 0, 4, 4, 0, "pre_reset_load");
    @(negedge clk);
    load = 1'b0; en = 1'b1; count_down = 1'b0;
    #1 chk("pre_reset_tc", {15'd0, tc}, 16'd1);
    #1 reset = 1'b0;
    #1 chk("async_clear", {13'd0, count}, 16'd0);
    chk("async_tc", {15'd0, tc}, 16'd0);
    @(posedge clk);
    #1 chk("reset_held", {13'd0, count}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_first", {13'd0, count}, 16'd1);
    m = 1;

    for (int i = 0; i < 300; i++) begin
      bit ld, e, d;
      int lv, ec;
      bit et;
      ld = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 9) < 7);
      d  = $urandom_range(0, 1);
      lv = $urandom_range(0, 7);
      et = model_tc(m, ld, e, d);
      ec = model_next(m, ld, e, d, lv);
      apply(ld, e, d, lv, ec, et, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
